// File: rtl/ps2_scancode_decoder.sv
// ----------------------------------------------------------------------------
// ps2_scancode_decoder
//
// Frame-level decoder that sits downstream of the PS/2 bit receiver. It checks
// each 11-bit frame's start, stop and odd-parity bits. It folds the E0
// (extended) and F0 (break) prefix bytes into a single key event. Events are
// queued in a small FIFO for the consumer. Malformed frames, unexpected
// prefixes and stale prefixes are dropped and flagged on frame_err.
//
// Parameters
//   FIFO_DEPTH      event FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES  clocks a prefix state may wait for the next frame
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous active-low reset
//   frame_valid  in   frame-ready strobe from the receiver (rising edge used)
//   frame[10:0]  in   [0] start, [8:1] data LSB-first, [9] parity, [10] stop
//   key_valid    out  FIFO non-empty, head event presented
//   key_code     out  head event scancode
//   key_ext      out  head event was E0-prefixed
//   key_release  out  head event was a break (F0-prefixed)
//   key_ready    in   consumer pops the head when key_valid & key_ready
//   frame_err    out  one-cycle pulse: bad frame, bad prefix or prefix timeout
//   overflow     out  one-cycle pulse: event dropped because the FIFO was full
//   err_count    out  saturating count of frame_err/overflow pulses
//
// Build option
//   PS2_DEC_ERRCNT_EN  when defined, err_count counts error pulses and
//                      saturates at 255. When undefined, err_count is tied to 0.
// ----------------------------------------------------------------------------
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [10:0] frame,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_ext,
    output logic        key_release,
    input  logic        key_ready,
    output logic        frame_err,
    output logic        overflow,
    output logic [7:0]  err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]    CODE_EXT  = 8'hE0;
    localparam logic [7:0]    CODE_BRK  = 8'hF0;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    // ------------------------------------------------------------------------
    // Strobe detect and frame capture
    // ------------------------------------------------------------------------
    logic        frame_valid_q;
    logic        cap_pend;      // rising edge seen, capture on next edge
    logic        hold_vld;      // holding register has a frame to check
    logic [10:0] hold_frame;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_valid_q <= 1'b0;
            cap_pend      <= 1'b0;
            hold_vld      <= 1'b0;
            hold_frame    <= '0;
        end else begin
            frame_valid_q <= frame_valid;
            cap_pend      <= frame_valid & ~frame_valid_q;
            hold_vld      <= cap_pend;
            if (cap_pend) begin
                hold_frame <= frame;
            end
        end
    end

    logic       frame_ok;
    logic [7:0] data_byte;

    assign frame_ok  = ~hold_frame[0] & hold_frame[10] & (^hold_frame[9:1]);
    assign data_byte = hold_frame[8:1];

    // ------------------------------------------------------------------------
    // Prefix FSM and timeout
    // ------------------------------------------------------------------------
    state_t          state;
    state_t          state_d;
    logic [TW-1:0]   to_cnt;
    logic            push;
    key_event_t      push_evt;
    logic            err_d;
    logic            is_prefix;

    assign is_prefix = (data_byte == CODE_EXT) || (data_byte == CODE_BRK);

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state;
        push     = 1'b0;
        push_evt = '0;
        err_d    = 1'b0;

        if (hold_vld) begin
            if (!frame_ok) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (data_byte == CODE_EXT) begin
                            state_d = S_EXT;
                        end else if (data_byte == CODE_BRK) begin
                            state_d = S_BRK;
                        end else begin
                            push     = 1'b1;
                            push_evt = '{ext: 1'b0, rel: 1'b0, code: data_byte};
                        end
                    end
                    S_EXT: begin
                        if (data_byte == CODE_BRK) begin
                            state_d = S_EXT_BRK;
                        end else if (data_byte == CODE_EXT) begin
                            state_d = S_EXT;
                        end else begin
                            push     = 1'b1;
                            push_evt = '{ext: 1'b1, rel: 1'b0, code: data_byte};
                            state_d  = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        state_d = S_IDLE;
                        if (is_prefix) begin
                            err_d = 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_evt = '{ext: 1'b0, rel: 1'b1, code: data_byte};
                        end
                    end
                    S_EXT_BRK: begin
                        state_d = S_IDLE;
                        if (is_prefix) begin
                            err_d = 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_evt = '{ext: 1'b1, rel: 1'b1, code: data_byte};
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end else if (state != S_IDLE && to_cnt == TO_LAST) begin
            // A prefix waited too long for its code byte: abandon it.
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Counter only runs while a prefix is pending, and restarts whenever a
    // new frame is captured so a slow but live typist never times out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (cap_pend || state == S_IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------------
    key_event_t      mem [FIFO_DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic            empty;
    logic            full;
    logic            pop;
    logic            do_write;
    logic            ovf_d;
    key_event_t      head;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop      = ~empty & key_ready;
    // A full FIFO can still accept a push when the head leaves the same cycle.
    assign do_write = push & (~full | pop);
    assign ovf_d    = push & full & ~pop;

    // NOTE: the storage array is deliberately not reset; emptiness is carried
    // by the pointers alone and the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr[AW-1:0]] <= push_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_write) begin
                wptr <= wptr + (AW + 1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW + 1)'(1);
            end
        end
    end

    assign head        = mem[rptr[AW-1:0]];
    assign key_valid   = ~empty;
    assign key_code    = empty ? 8'h00 : head.code;
    assign key_ext     = ~empty & head.ext;
    assign key_release = ~empty & head.rel;

    // ------------------------------------------------------------------------
    // Error pulses and optional error counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= err_d;
            overflow  <= ovf_d;
        end
    end

`ifdef PS2_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Counts in step with the pulse registers, so err_count already includes
    // a pulse during the cycle that pulse is visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q <= 8'h00;
        end else if ((err_d || ovf_d) && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_scancode_decoder
//
// Directed self-checking bench for ps2_scancode_decoder. Each task drives one
// scenario and compares outputs against hand-computed values. Expected
// err_count follows the PS2_DEC_ERRCNT_EN build option.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_scancode_decoder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic [10:0] frame;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_release;
    logic        key_ready;
    logic        frame_err;
    logic        overflow;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_err  = 0;

    ps2_scancode_decoder #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .frame      (frame),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_release(key_release),
        .key_ready  (key_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge E samples the rise, E+1 captures, E+2 checks; returns after E+2.
    task automatic send_frame(input logic [10:0] f);
        frame       = f;
        frame_valid = 1'b1;
        tick();
        tick();
        frame_valid = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    task automatic note_error();
`ifdef PS2_DEC_ERRCNT_EN
        if (exp_err < 255) exp_err++;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid);
        else n_pass++;
        n_checks++;
        if ({key_code, key_ext, key_release} !== 10'h000)
            $display("FAIL reset_key_fields: got %h/%b/%b expected 00/0/0", key_code, key_ext, key_release);
        else n_pass++;
        n_checks++;
        if ({frame_err, overflow} !== 2'b00)
            $display("FAIL reset_pulses: got %b%b expected 00", frame_err, overflow);
        else n_pass++;
        n_checks++;
        if (err_count !== 8'h00) $display("FAIL reset_err_count: got %0d expected 0", err_count);
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_make();
        frame       = 11'h438;
        frame_valid = 1'b1;
        tick();
        tick();
        frame_valid = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL make_early: got key_valid=%b after E+1 expected 0", key_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({key_valid, key_ext, key_release, key_code} !== {3'b100, 8'h1C})
            $display("FAIL make_event: got v=%b e=%b r=%b c=%h expected v=1 e=0 r=0 c=1c",
                     key_valid, key_ext, key_release, key_code);
        else n_pass++;
        n_checks++;
        if (frame_err !== 1'b0) $display("FAIL make_no_err: got %b expected 0", frame_err);
        else n_pass++;
        pop_one();
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL make_pop_empty: got key_valid=%b expected 0", key_valid);
        else n_pass++;
    endtask

    task automatic test_break();
        send_frame(11'h7E0);
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL break_prefix_no_event: got key_valid=%b expected 0", key_valid);
        else n_pass++;
        send_frame(11'h438);
        n_checks++;
        if ({key_valid, key_ext, key_release, key_code} !== {3'b101, 8'h1C})
            $display("FAIL break_event: got v=%b e=%b r=%b c=%h expected v=1 e=0 r=1 c=1c",
                     key_valid, key_ext, key_release, key_code);
        else n_pass++;
        pop_one();
    endtask

    task automatic test_ext_break();
        send_frame(11'h5C0);
        send_frame(11'h7E0);
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL ext_break_prefix_no_event: got key_valid=%b expected 0", key_valid);
        else n_pass++;
        send_frame(11'h4EA);
        n_checks++;
        if ({key_valid, key_ext, key_release, key_code} !== {3'b111, 8'h75})
            $display("FAIL ext_break_event: got v=%b e=%b r=%b c=%h expected v=1 e=1 r=1 c=75",
                     key_valid, key_ext, key_release, key_code);
        else n_pass++;
        pop_one();
    endtask

    task automatic test_bad_frames();
        logic [10:0] bad [3];
        bad[0] = 11'h638;   // parity wrong
        bad[1] = 11'h439;   // start bit set
        bad[2] = 11'h038;   // stop bit clear
        for (int i = 0; i < 3; i++) begin
            send_frame(bad[i]);
            note_error();
            n_checks++;
            if ({frame_err, key_valid} !== 2'b10)
                $display("FAIL bad_frame_%0d: got err=%b valid=%b expected err=1 valid=0", i, frame_err, key_valid);
            else n_pass++;
            n_checks++;
            if (err_count !== 8'(exp_err))
                $display("FAIL bad_frame_%0d_count: got %0d expected %0d", i, err_count, exp_err);
            else n_pass++;
            tick();
            n_checks++;
            if (frame_err !== 1'b0) $display("FAIL bad_frame_%0d_pulse_len: got %b expected 0", i, frame_err);
            else n_pass++;
        end
    endtask

    task automatic test_bad_prefix();
        send_frame(11'h7E0);
        send_frame(11'h5C0);   // E0 after F0 is illegal
        note_error();
        n_checks++;
        if ({frame_err, key_valid} !== 2'b10)
            $display("FAIL bad_prefix: got err=%b valid=%b expected err=1 valid=0", frame_err, key_valid);
        else n_pass++;
        send_frame(11'h438);
        n_checks++;
        if ({key_valid, key_ext, key_release, key_code} !== {3'b100, 8'h1C})
            $display("FAIL bad_prefix_recover: got v=%b e=%b r=%b c=%h expected v=1 e=0 r=0 c=1c",
                     key_valid, key_ext, key_release, key_code);
        else n_pass++;
        pop_one();
    endtask

    task automatic test_timeout();
        int first = 0;
        send_frame(11'h5C0);
        for (int k = 1; k <= TIMEOUT + 5; k++) begin
            tick();
            if (frame_err === 1'b1 && first == 0) first = k;
        end
        note_error();
        n_checks++;
        if (first != TIMEOUT)
            $display("FAIL timeout_cycle: got pulse at cycle %0d expected %0d (0 means none)", first, TIMEOUT);
        else n_pass++;
        n_checks++;
        if (err_count !== 8'(exp_err)) $display("FAIL timeout_count: got %0d expected %0d", err_count, exp_err);
        else n_pass++;
        send_frame(11'h438);
        n_checks++;
        if ({key_valid, key_ext, key_release, key_code} !== {3'b100, 8'h1C})
            $display("FAIL timeout_recover: got v=%b e=%b r=%b c=%h expected v=1 e=0 r=0 c=1c",
                     key_valid, key_ext, key_release, key_code);
        else n_pass++;
        pop_one();
    endtask

    task automatic test_overflow();
        int ovf_seen = 0;
        logic [7:0] exp_codes [4];
        key_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_frame(11'h438);
            if (overflow === 1'b1) ovf_seen++;
            n_checks++;
            if (overflow !== (i >= DEPTH))
                $display("FAIL overflow_frame_%0d: got %b expected %b", i, overflow, (i >= DEPTH));
            else n_pass++;
            if (i >= DEPTH) note_error();
        end
        n_checks++;
        if (ovf_seen != 2) $display("FAIL overflow_total: got %0d expected 2", ovf_seen);
        else n_pass++;
        n_checks++;
        if (err_count !== 8'(exp_err)) $display("FAIL overflow_count: got %0d expected %0d", err_count, exp_err);
        else n_pass++;

        // Push and pop on the same edge while full: both must happen.
        frame       = 11'h4EA;
        frame_valid = 1'b1;
        tick();
        tick();
        frame_valid = 1'b0;
        key_ready   = 1'b1;
        tick();
        key_ready   = 1'b0;
        n_checks++;
        if ({overflow, key_valid} !== 2'b01)
            $display("FAIL full_push_pop: got ovf=%b valid=%b expected ovf=0 valid=1", overflow, key_valid);
        else n_pass++;

        exp_codes[0] = 8'h1C;
        exp_codes[1] = 8'h1C;
        exp_codes[2] = 8'h1C;
        exp_codes[3] = 8'h75;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({key_valid, key_code} !== {1'b1, exp_codes[i]})
                $display("FAIL drain_%0d: got v=%b c=%h expected v=1 c=%h", i, key_valid, key_code, exp_codes[i]);
            else n_pass++;
            pop_one();
        end
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL drain_empty: got key_valid=%b expected 0", key_valid);
        else n_pass++;
        // Pop while empty is ignored and must not disturb later pushes.
        pop_one();
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(11'h438);
        send_frame(11'h5C0);   // leave the FSM in EXT
        rst = 1'b0;
        tick();
        exp_err = 0;
        n_checks++;
        if ({key_valid, key_code, key_ext, key_release} !== 11'h000)
            $display("FAIL mid_reset_outputs: got v=%b c=%h e=%b r=%b expected all 0",
                     key_valid, key_code, key_ext, key_release);
        else n_pass++;
        n_checks++;
        if (err_count !== 8'h00) $display("FAIL mid_reset_count: got %0d expected 0", err_count);
        else n_pass++;
        rst = 1'b1;
        tick();
        send_frame(11'h438);
        n_checks++;
        if ({key_valid, key_ext, key_release, key_code} !== {3'b100, 8'h1C})
            $display("FAIL mid_reset_recover: got v=%b e=%b r=%b c=%h expected v=1 e=0 r=0 c=1c",
                     key_valid, key_ext, key_release, key_code);
        else n_pass++;
        pop_one();
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL mid_reset_single_entry: got key_valid=%b expected 0", key_valid);
        else n_pass++;
    endtask

    initial begin
        rst         = 1'b0;
        frame_valid = 1'b0;
        frame       = '0;
        key_ready   = 1'b0;

        test_reset();
        test_make();
        test_break();
        test_ext_break();
        test_bad_frames();
        test_bad_prefix();
        test_timeout();
        test_overflow();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
